instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Supplies 16-bit XM instruction words to the instruction decoder.
- Drives a req/ack read port into instruction memory and keeps a small prefetch FIFO of {pc, instruction} pairs.
- Presents the FIFO head to the decoder with a valid/stall handshake, which feeds the decoder's inst_data/en.
- Accepts branch redirects from the execution unit: the FIFO is flushed, and any in-flight read is drained and discarded.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset. Bit 0 is ignored.
- BUF_DEPTH, 2, prefetch FIFO entries. Legal values are 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_en  input  1  permits new memory requests.
- stall  input  1  decoder not accepting this cycle.
- redirect  input  1  branch taken; flush and refetch.
- redirect_pc  input  16  new fetch address. Bit 0 is ignored.
- mem_req  output  1  read request, registered.
- mem_addr  output  16  read address, registered; stable while mem_req=1.
- mem_ack  input  1  read complete; mem_rdata is valid this cycle.
- mem_rdata  input  16  instruction word.
- inst_valid  output  1  FIFO head valid; drives the decoder en.
- inst_data  output  16  FIFO head instruction.
- inst_pc  output  16  address of the FIFO head instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, fetch_pc=RESET_PC&~1.
  - mem_req=0, mem_addr=RESET_PC&~1.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-request abandons the request; memory is also reset.
- Addresses are word-aligned. fetch_pc[0] is always 0. Increment is +2 with 16-bit wrap (16'hFFFE -> 16'h0000).
- FIFO:
  - pop = inst_valid & ~stall.
  - push = accepted ack in state REQ with no redirect that cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is only issued or continued when count_next < BUF_DEPTH, and only one read is ever outstanding.
- Outputs:
  - inst_valid = (count != 0) & ~redirect (combinational).
  - inst_data and inst_pc show the head entry, and are 0 when count = 0.
- IDLE state:
  - mem_req=0.
  - If fetch_en and count < BUF_DEPTH and ~redirect: mem_addr<=fetch_pc, mem_req<=1, go to REQ.
- REQ state:
  - mem_req=1 and mem_addr is held until mem_ack.
  - On mem_ack without redirect:
    - Push {mem_addr, mem_rdata}; fetch_pc<=fetch_pc+2.
    - If fetch_en and count_next < BUF_DEPTH: issue the next request back-to-back (mem_addr<=fetch_pc+2, stay in REQ).
    - Otherwise mem_req<=0 and go to IDLE.
  - If fetch_en drops, the outstanding read still completes normally.
- Redirect (highest priority, any state):
  - count<=0 (the pop is ignored); fetch_pc<=redirect_pc&~1.
  - In REQ without mem_ack: go to DISCARD. mem_req stays 1 with the old address; the protocol forbids withdrawal.
  - In REQ with mem_ack the same cycle: data dropped, mem_req<=0, go to IDLE.
  - In IDLE: stay in IDLE. Fetching resumes from the new pc the next cycle.
  - In DISCARD: update fetch_pc and stay in DISCARD.
- DISCARD state:
  - Hold the request.
  - On mem_ack: drop the data, mem_req<=0, go to IDLE. Nothing is pushed and fetch_pc is not incremented.
- Latency:
  - Reset release with fetch_en=1: mem_req=1 at the 1st edge. With mem_ack in that cycle, inst_valid=1 after the 2nd edge.
  - Zero-wait memory sustains 1 instruction per cycle while ~stall.
- Stall:
  - Holds the head stable.
  - The FIFO fills to BUF_DEPTH, then mem_req deasserts after the filling ack.
- mem_ack while in IDLE is illegal and ignored.

Test Plan:
- Reset with RESET_PC=16'h0100, fetch_en=1, zero-wait memory returning mem_addr as data -> mem_addr sequence 0100, 0102, 0104 on consecutive cycles; inst_valid=1 from cycle 2; inst_pc/inst_data = 0100/0100, then 0102/0102.
- stall=1 held for 6 cycles, BUF_DEPTH=2 -> exactly 2 pushes and mem_req=0. The head stays 0100. After stall drops, entries pop in order with no loss or duplication.
- Redirect to 16'h2001 while a request to 0104 is outstanding, with ack 3 cycles later -> DISCARD state, mem_addr holds 0104, 0104 data is dropped. The next request is to 2000; inst_valid=0 until 2000 is pushed.
- redirect and mem_ack in the same cycle -> ack data dropped, count=0, next request to the redirect target. The pop in that cycle is ignored (inst_valid=0).
- fetch_pc=16'hFFFE with continuous fetch -> next mem_addr=16'h0000.
- reset asserted while mem_req=1 -> all outputs are at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: prefetches XM words over a req/ack port into a FIFO of {pc, inst} pairs.
// Latency: request one edge after enable, word visible one edge after ack; 1 word/cycle on zero-wait memory.
// Backpressure: decoder stall holds the FIFO head; requests stop once the FIFO would be full.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc
);

    localparam int              CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [15:0]     PC0     = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state, state_nx;
    logic [15:0]   fetch_pc, fetch_pc_nx, mem_addr_nx;
    logic          mem_req_nx;
    logic          push, pop;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   head;

    assign inst_valid = (count != '0) & ~redirect;
    assign pop        = inst_valid & ~stall;
    assign push       = (state == REQ) & mem_ack & ~redirect;
    assign inst_pc    = head[31:16];
    assign inst_data  = head[15:0];

    always_comb begin
        count_nx = count;
        if (redirect)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + CW'(1);
        else if (pop && !push)
            count_nx = count - CW'(1);
    end

    ifu_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect),
        .push   (push),
        .pop    (pop),
        .wr_dat ({mem_addr, mem_rdata}),
        .count  (count),
        .head   (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= PC0;
            mem_req  <= 1'b0;
            mem_addr <= PC0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            mem_req  <= mem_req_nx;
            mem_addr <= mem_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        mem_req_nx  = mem_req;
        mem_addr_nx = mem_addr;
        if (redirect)
            fetch_pc_nx = redirect_pc & 16'hFFFE;
        case (state)
            IDLE: begin
                mem_req_nx = 1'b0;
                if (!redirect && fetch_en && (count < DEPTH_C)) begin
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = fetch_pc;
                    state_nx    = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // A request cannot be withdrawn; wait out its ack in DISCARD.
                    if (mem_ack) begin
                        mem_req_nx = 1'b0;
                        state_nx   = IDLE;
                    end else begin
                        state_nx   = DISCARD;
                    end
                end else if (mem_ack) begin
                    fetch_pc_nx = fetch_pc + 16'd2;
                    if (fetch_en && (count_nx < DEPTH_C)) begin
                        mem_addr_nx = fetch_pc + 16'd2;
                    end else begin
                        mem_req_nx = 1'b0;
                        state_nx   = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    mem_req_nx = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// Generic circular FIFO with flush; head reads as zero when empty.
// Latency: a pushed entry is visible at the head one edge later.
// Backpressure: none internally; caller never pushes when full or pops when empty.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_dat;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_instruction_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, stall, redirect, mem_ack;
    logic [15:0] redirect_pc, mem_rdata;
    logic        mem_req, inst_valid;
    logic [15:0] mem_addr, inst_data, inst_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: prefetch queue, outstanding-read flag, and a flag for a read being thrown away.
    logic [31:0] q[$];
    logic [15:0] m_pc, m_addr, key;
    logic        m_req, m_disc;

    task automatic model_reset();
        q.delete();
        m_pc   = RST_PC & 16'hFFFE;
        m_addr = RST_PC & 16'hFFFE;
        m_req  = 1'b0;
        m_disc = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(mem_req),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),   32'(RST_PC & 16'hFFFE));
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_data"},  32'(inst_data),  32'd0);
        chk({tag, "_pc"},    32'(inst_pc),    32'd0);
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cyc(input logic fe, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic ak);
        int          c0;
        logic        pp, got, ev;
        logic [31:0] h;
        fetch_en    = fe;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        mem_ack     = ak;
        mem_rdata   = mem_addr ^ key;
        #1;
        c0 = q.size();
        h  = (c0 != 0) ? q[0] : 32'h0;
        ev = (c0 != 0) && !rd;
        chk("mem_req",    32'(mem_req),    32'(m_req));
        chk("mem_addr",   32'(mem_addr),   32'(m_addr));
        chk("inst_valid", 32'(inst_valid), 32'(ev));
        chk("inst_pc",    32'(inst_pc),    32'(h[31:16]));
        chk("inst_data",  32'(inst_data),  32'(h[15:0]));
        pp  = ev && !st;
        got = m_req && ak;
        if (rd) begin
            q.delete();
            m_pc = rpc & 16'hFFFE;
            if (got) begin
                m_req  = 1'b0;
                m_disc = 1'b0;
            end else if (m_req) begin
                m_disc = 1'b1;
            end
        end else begin
            if (pp)
                void'(q.pop_front());
            if (got && m_disc) begin
                m_req  = 1'b0;
                m_disc = 1'b0;
            end else if (got) begin
                q.push_back({m_addr, mem_rdata});
                m_pc = m_pc + 16'd2;
                if (fe && q.size() < DEPTH)
                    m_addr = m_pc;
                else
                    m_req = 1'b0;
            end else if (!m_req && fe && c0 < DEPTH) begin
                m_addr = m_pc;
                m_req  = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic        seen, done;
        reset = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0; key = 16'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait memory returning the address as data.
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Asynchronous reset in the middle of a request.
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("rst_async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Stall fills the FIFO and stops requests; head stays on the reset pc.
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("stall_req",  32'(mem_req), 32'd0);
        chk("stall_head", 32'(inst_pc), 32'h0100);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect with a read outstanding; ack arrives three cycles later.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        held = m_addr;
        cyc(1'b1, 1'b0, 1'b1, 16'h2001, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("disc_hold_addr", 32'(mem_addr), 32'(held));
        chk("disc_hold_req",  32'(mem_req),  32'd1);
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect coinciding with ack.
        cyc(1'b1, 1'b0, 1'b1, 16'h4000, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Address wrap from FFFE to 0000.
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (seen) begin
                chk("wrap_addr", 32'(mem_addr), 32'h0000);
                done = 1'b1;
            end else begin
                if (mem_req && mem_addr == 16'hFFFE)
                    seen = 1'b1;
                cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            end
        end
        chk("wrap_reached", 32'(done), 32'd1);

        // Random traffic, including stray acks while idle.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0)
                key = 16'($urandom);
            cyc($urandom_range(9) != 0, $urandom_range(9) < 3, $urandom_range(19) == 0,
                16'($urandom), $urandom_range(9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
